rf_write_queue: RTL and testbench
=================================

# rf_write_queue

Posted-write buffer that sits between the pipeline's writeback stage and the `s_regFile` write port (DestReg/WriteData/WE). It accepts results with a valid/ready handshake, holds up to DEPTH pending writes in order, and drains one per cycle into the register file. While writes are pending it forwards the youngest queued value for the two decode-stage source registers, so reads never return stale register-file contents.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `REG_WIDTH`, 32, data width; matches register file
- `IDX_WIDTH`, 5, register index width; matches `MUX_CNTRL`
- `Clk` input 1: single clock; all state updates on posedge
- `Reset` input 1: asynchronous, active-high; clears queue
- `in_valid` input 1: writeback result offered
- `in_dest` input IDX_WIDTH: destination register index
- `in_data` input REG_WIDTH: result value
- `in_ready` output 1: queue can accept this cycle
- `rf_stall` input 1: suppress drain this cycle
- `rf_we` output 1: to register file WE
- `rf_dest` output IDX_WIDTH: to register file DestReg
- `rf_wdata` output REG_WIDTH: to register file WriteData
- `srcA`, `srcB` input IDX_WIDTH: decode source indices
- `fwdA_hit`, `fwdB_hit` output 1: a pending write matches srcA/srcB
- `fwdA_data`, `fwdB_data` output REG_WIDTH: forwarded value (0 when no hit)
- `count` output clog2(DEPTH)+1: entries held
- `empty` output 1: count == 0

## Operation
- Circular buffer: head/tail pointers of clog2(DEPTH) bits, wrap modulo DEPTH; `count` tracks occupancy separately.
- Push: `in_valid && in_ready` at posedge writes {in_dest, in_data} at tail, tail+1.
- `in_ready` = !full; there is no same-cycle pass-through when full, even if a pop occurs that cycle.
- Drain: `rf_we` = !empty && !rf_stall; `rf_dest`/`rf_wdata` show the head entry combinationally. When empty they are 0.
- Pop: at posedge when `rf_we`=1, head+1. The register file latches on the negedge inside the same cycle, so the popped value is already architecturally visible when the entry leaves the queue.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding: combinational compare of srcA/srcB against all valid entries. The youngest match (closest to tail) wins. The entry currently being drained counts as valid. The in-flight `in_*` value is not forwarded.
- Multiple pending writes to the same index are all drained in order; none are merged.
- Reset (any time, including mid-drain): pointers=0, count=0, `empty`=1, `in_ready`=1, `rf_we`=0, `rf_dest`=0, `rf_wdata`=0, fwd hits=0, fwd data=0. Pending entries are discarded. Storage array contents need not be cleared.

## Timing
- Push-to-drain latency: 1 cycle. An entry pushed at edge N drives `rf_we` in cycle N..N+1 and is in the register file by that cycle's negedge.
- Forwarding is available the cycle after the push and stays available through the cycle the entry drains.
- Throughput: 1 push and 1 drain per cycle sustained.
- `rf_stall` holds the head stable. `rf_dest`/`rf_wdata` do not change while stalled unless Reset asserts.
- While full and `rf_stall`=1, `in_ready`=0 indefinitely; the producer must hold `in_valid`/data.

## Configuration
- `RFWQ_R0_DISCARD_EN` defined: a push with `in_dest`=0 is accepted (in_ready rules unchanged) but not stored; srcA/srcB=0 never hit. This models a hardwired-zero r0.
- Undefined: r0 is an ordinary register; writes are queued, drained and forwarded like any other.

## Test plan
- Reset, then push (dest 3, 0xDEADBEEF) → next cycle `rf_we`=1, `rf_dest`=3, `rf_wdata`=0xDEADBEEF, `fwdA_hit`=1 for srcA=3; the cycle after, empty=1 and register 3 reads 0xDEADBEEF.
- `rf_stall`=1; push (5,0x11), (5,0x22), (7,0x33), (9,0x44) → count=4, in_ready=0, srcA=5 gives 0x22, srcB=9 gives 0x44; release stall → four drains in order over 4 cycles.
- Full queue with stall released and `in_valid` held → in_ready stays 0 on the pop cycle and goes 1 the next cycle; no entry is lost or duplicated; pointers wrap past DEPTH-1 correctly.
- Continuous push every cycle with no stall for 20 cycles → count stays ≤1, `rf_we` stays high from cycle 2 on, and register-file contents match the push sequence.
- Assert Reset mid-drain with count=3 → all outputs return to reset values immediately; the entries do not reach the register file after Reset; the next push drains normally.
- Push (0, 0x55): with `RFWQ_R0_DISCARD_EN`, count stays 0 and srcA=0 gives no hit; without it, `rf_dest`=0, `rf_wdata`=0x55 and the write is forwarded.

Source files
------------

// File: rtl/rf_write_queue.sv
// Posted-write buffer between writeback and the register-file write port, with youngest-entry
// forwarding for the two decode sources. Define RFWQ_R0_DISCARD_EN to model a hardwired-zero r0.
module rf_write_queue #(
    parameter int DEPTH     = 4,
    parameter int REG_WIDTH = 32,
    parameter int IDX_WIDTH = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   in_valid,
    input  logic [IDX_WIDTH-1:0]   in_dest,
    input  logic [REG_WIDTH-1:0]   in_data,
    output logic                   in_ready,
    input  logic                   rf_stall,
    output logic                   rf_we,
    output logic [IDX_WIDTH-1:0]   rf_dest,
    output logic [REG_WIDTH-1:0]   rf_wdata,
    input  logic [IDX_WIDTH-1:0]   srcA,
    input  logic [IDX_WIDTH-1:0]   srcB,
    output logic                   fwdA_hit,
    output logic                   fwdB_hit,
    output logic [REG_WIDTH-1:0]   fwdA_data,
    output logic [REG_WIDTH-1:0]   fwdB_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_WIDTH-1:0] dest_mem_r [DEPTH];
    logic [REG_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic store_s;
    logic pop_s;
    logic discard_s;

    // Scan the valid entries oldest-to-youngest so the last match (closest to tail) wins.
    function automatic logic [REG_WIDTH:0] fwd_lookup(input logic [IDX_WIDTH-1:0] src);
        logic [REG_WIDTH:0] res;
        logic [PTR_W-1:0]   idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_r + PTR_W'(k);
            if ((CNT_W'(k) < count_r) && (dest_mem_r[idx] == src)) begin
                res = {1'b1, data_mem_r[idx]};
            end else begin
                res = res;
            end
        end
`ifdef RFWQ_R0_DISCARD_EN
        if (src == '0) begin
            res = '0;
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign empty_s  = (count_r == '0);
    assign push_s   = in_valid && !full_s;
    assign pop_s    = !empty_s && !rf_stall;
`ifdef RFWQ_R0_DISCARD_EN
    assign discard_s = (in_dest == '0);
`else
    assign discard_s = 1'b0;
`endif
    assign store_s  = push_s && !discard_s;

    assign in_ready = !full_s;
    assign count    = count_r;
    assign empty    = empty_s;

    // Drain port shows the head entry; forwarding results for both decode sources.
    always_comb begin
        rf_we = pop_s;
        if (empty_s) begin
            rf_dest  = '0;
            rf_wdata = '0;
        end else begin
            rf_dest  = dest_mem_r[head_r];
            rf_wdata = data_mem_r[head_r];
        end
        {fwdA_hit, fwdA_data} = fwd_lookup(srcA);
        {fwdB_hit, fwdB_data} = fwd_lookup(srcB);
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (store_s) begin
            dest_mem_r[tail_r] <= in_dest;
            data_mem_r[tail_r] <= in_data;
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (store_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: queue-based reference model checked every negedge, plus
// hand-computed expectations for each directed scenario.
module tb_rf_write_queue;

    localparam int DEPTH = 4;

`ifdef RFWQ_R0_DISCARD_EN
    localparam bit R0D = 1'b1;
`else
    localparam bit R0D = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic [4:0]  in_dest;
    logic [31:0] in_data;
    logic        in_ready;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_wdata;
    logic [4:0]  srcA;
    logic [4:0]  srcB;
    logic        fwdA_hit;
    logic        fwdB_hit;
    logic [31:0] fwdA_data;
    logic [31:0] fwdB_data;
    logic [2:0]  count;
    logic        empty;

    int pass_cnt = 0;
    int total    = 0;

    ent_t        q[$];
    logic [31:0] model_rf[32];
    logic [31:0] dut_rf[32];

    rf_write_queue #(.DEPTH(DEPTH), .REG_WIDTH(32), .IDX_WIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data), .in_ready(in_ready),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
        .srcA(srcA), .srcB(srcB),
        .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
        .count(count), .empty(empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = v;
        cycle();
        in_valid = 1'b0;
    endtask

    // Reference model: pending writes as an ordered list, register file as an array.
    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'd0;
            dut_rf[i]   = 32'd0;
        end
        forever begin
            bit acc;
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                q.delete();
            end else begin
                acc = in_valid && (q.size() < DEPTH);
                if (q.size() > 0 && !rf_stall) begin
                    model_rf[q[0].dest] = q[0].data;
                    void'(q.pop_front());
                end
                if (acc && !(R0D && in_dest == 5'd0)) begin
                    q.push_back({in_dest, in_data});
                end
            end
        end
    end

    // Compare every cycle, then let the DUT's write port update the bench-side register file.
    initial begin
        forever begin
            logic        e_hitA, e_hitB;
            logic [31:0] e_datA, e_datB;
            @(negedge Clk);
            e_hitA = 1'b0; e_datA = 32'd0;
            e_hitB = 1'b0; e_datB = 32'd0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!e_hitA && q[i].dest == srcA && !(R0D && srcA == 5'd0)) begin
                    e_hitA = 1'b1; e_datA = q[i].data;
                end
                if (!e_hitB && q[i].dest == srcB && !(R0D && srcB == 5'd0)) begin
                    e_hitB = 1'b1; e_datB = q[i].data;
                end
            end
            chk("count",     count,     q.size());
            chk("empty",     empty,     q.size() == 0);
            chk("in_ready",  in_ready,  q.size() < DEPTH);
            chk("rf_we",     rf_we,     q.size() > 0 && !rf_stall);
            chk("rf_dest",   rf_dest,   (q.size() > 0) ? q[0].dest : 5'd0);
            chk("rf_wdata",  rf_wdata,  (q.size() > 0) ? q[0].data : 32'd0);
            chk("fwdA_hit",  fwdA_hit,  e_hitA);
            chk("fwdA_data", fwdA_data, e_datA);
            chk("fwdB_hit",  fwdB_hit,  e_hitB);
            chk("fwdB_data", fwdB_data, e_datB);
            if (rf_we) dut_rf[rf_dest] = rf_wdata;
        end
    end

    initial begin
        Reset = 1'b0; in_valid = 1'b0; in_dest = 5'd0; in_data = 32'd0;
        rf_stall = 1'b0; srcA = 5'd0; srcB = 5'd0;
        #1 Reset = 1'b1;
        cycle(); cycle();
        chk("rst_count",    count,    3'd0);
        chk("rst_empty",    empty,    1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rf_we",    rf_we,    1'b0);
        Reset = 1'b0;
        cycle();

        // Single write, one-cycle latency, forwarded while pending.
        srcA = 5'd3;
        push(5'd3, 32'hDEADBEEF);
        chk("t1_we",    rf_we,     1'b1);
        chk("t1_dest",  rf_dest,   5'd3);
        chk("t1_wdata", rf_wdata,  32'hDEADBEEF);
        chk("t1_hitA",  fwdA_hit,  1'b1);
        chk("t1_datA",  fwdA_data, 32'hDEADBEEF);
        cycle();
        chk("t1_empty", empty,     1'b1);
        chk("t1_reg3",  dut_rf[3], 32'hDEADBEEF);

        // Fill while stalled; youngest duplicate wins forwarding; in-order drain.
        rf_stall = 1'b1; srcA = 5'd5; srcB = 5'd9;
        push(5'd5, 32'h11); push(5'd5, 32'h22); push(5'd7, 32'h33); push(5'd9, 32'h44);
        chk("t2_count", count,     3'd4);
        chk("t2_ready", in_ready,  1'b0);
        chk("t2_datA",  fwdA_data, 32'h22);
        chk("t2_datB",  fwdB_data, 32'h44);
        rf_stall = 1'b0;
        repeat (4) cycle();
        chk("t2_empty", empty,     1'b1);
        chk("t2_reg5",  dut_rf[5], 32'h22);
        chk("t2_reg7",  dut_rf[7], 32'h33);
        chk("t2_reg9",  dut_rf[9], 32'h44);

        // Full with held producer: no pass-through on the pop cycle; pointers wrap.
        rf_stall = 1'b1;
        push(5'd10, 32'hA0); push(5'd11, 32'hA1); push(5'd13, 32'hA2); push(5'd14, 32'hA3);
        in_valid = 1'b1; in_dest = 5'd12; in_data = 32'hA4; rf_stall = 1'b0;
        #1;
        chk("t3_ready_full", in_ready, 1'b0);
        cycle();
        chk("t3_ready_next", in_ready, 1'b1);
        chk("t3_count_pop",  count,    3'd3);
        cycle();
        in_valid = 1'b0;
        chk("t3_count_both", count,    3'd3);
        repeat (4) cycle();
        chk("t3_empty",  empty,      1'b1);
        chk("t3_reg12",  dut_rf[12], 32'hA4);
        chk("t3_reg14",  dut_rf[14], 32'hA3);

        // Back-to-back pushes with no stall.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_dest = 5'(i % 7 + 1); in_data = 32'h1000 + 32'(i);
            cycle();
            chk("t4_count", count, 3'd1);
            chk("t4_we",    rf_we, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        chk("t4_empty", empty, 1'b1);

        // Reset in the middle of a drain.
        srcA = 5'd21; rf_stall = 1'b1;
        push(5'd20, 32'h200); push(5'd21, 32'h201); push(5'd22, 32'h202); push(5'd23, 32'h203);
        rf_stall = 1'b0;
        cycle();
        chk("t5_count3", count, 3'd3);
        chk("t5_we_pre", rf_we, 1'b1);
        Reset = 1'b1;
        #1;
        chk("t5_we",    rf_we,     1'b0);
        chk("t5_count", count,     3'd0);
        chk("t5_empty", empty,     1'b1);
        chk("t5_ready", in_ready,  1'b1);
        chk("t5_dest",  rf_dest,   5'd0);
        chk("t5_wdata", rf_wdata,  32'd0);
        chk("t5_hitA",  fwdA_hit,  1'b0);
        chk("t5_datA",  fwdA_data, 32'd0);
        cycle();
        Reset = 1'b0;
        cycle();
        chk("t5_reg20", dut_rf[20], 32'h200);
        chk("t5_reg21", dut_rf[21], 32'd0);
        push(5'd25, 32'h99);
        cycle();
        chk("t5_reg25", dut_rf[25], 32'h99);
        chk("t5_empty2", empty, 1'b1);

        // Writes to r0.
        srcA = 5'd0;
        push(5'd0, 32'h55);
`ifdef RFWQ_R0_DISCARD_EN
        chk("t6_count", count,    3'd0);
        chk("t6_hitA",  fwdA_hit, 1'b0);
`else
        chk("t6_we",    rf_we,     1'b1);
        chk("t6_dest",  rf_dest,   5'd0);
        chk("t6_wdata", rf_wdata,  32'h55);
        chk("t6_hitA",  fwdA_hit,  1'b1);
        chk("t6_datA",  fwdA_data, 32'h55);
`endif
        cycle(); cycle();

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile[%0d]", i), dut_rf[i], model_rf[i]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
